// File: rtl/csr_access_pkg.sv
// rtl/csr_access_pkg.sv - sequencer state encoding and CSR address constants
//
// Purpose: types local to csr_access_unit.
// Contents: csr_acc_state_t, CSR_RO_BITS (addr[11:10] pattern of read-only CSRs).
package csr_access_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } csr_acc_state_t;

  localparam logic [1:0] CSR_RO_BITS = 2'b11;

endpackage

// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared RV32I scalar types and Zicsr funct3 encodings
//
// Purpose: common datapath types used by the CSR access path.
// Contents: word_t, csr_addr_t, reg_idx_t, csr_funct3_t.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [11:0] csr_addr_t;
  typedef logic [4:0]  reg_idx_t;

  // 3'b000 and 3'b100 are not Zicsr operations and decode as illegal.
  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_funct3_t;

endpackage

// File: rtl/csr_op_decode.sv
// rtl/csr_op_decode.sv - combinational Zicsr funct3/operand decoder
//
// Purpose: maps funct3 and the rs1 field to one CSR operation and its operand.
// Ports:
//   funct3   in  3   Zicsr funct3
//   rs1_data in  32  register operand
//   rs1_uimm in  5   rs1 field (register index or zimm)
//   swap     out 1   read-and-write operation
//   set      out 1   read-and-set operation (suppressed when rs1 field is 0)
//   clr      out 1   read-and-clear operation (suppressed when rs1 field is 0)
//   illegal  out 1   funct3 is not a Zicsr operation
//   operand  out 32  zero-extended zimm for immediate forms, else rs1_data
module csr_op_decode
  import rv32i_types_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  rs1_uimm,
  output logic        swap,
  output logic        set,
  output logic        clr,
  output logic        illegal,
  output logic [31:0] operand
);

  always_comb begin
    swap    = 1'b0;
    set     = 1'b0;
    clr     = 1'b0;
    illegal = 1'b0;
    operand = funct3[2] ? {27'd0, rs1_uimm} : rs1_data;
    case (funct3)
      CSRRW, CSRRWI: swap = 1'b1;
      // rs1 field of zero turns set/clear into a side-effect-free read
      CSRRS, CSRRSI: set  = (rs1_uimm != 5'd0);
      CSRRC, CSRRCI: clr  = (rs1_uimm != 5'd0);
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - pipeline-side Zicsr sequencer in front of the CSR file
//
// Purpose: accepts one decoded CSR instruction, issues a single-cycle strobe to
// the CSR file, returns the old value (or an illegal flag) to writeback, and
// holds off new requests for SETTLE_CYCLES idle cycles after any CSR write.
// Optional macro: CSR_RO_WRITE_CHECK_EN - writes to addr[11:10]==2'b11 become
// illegal and are not strobed.
// Ports:
//   CLK, nRST                          clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake
//   funct3, csr_addr, rs1_data,
//   rs1_uimm, rd_addr                  decoded instruction fields
//   flush                              squash in-flight request
//   csr_swap/csr_clr/csr_set,
//   csr_addr_o, csr_wdata              CSR file strobes (ISSUE only)
//   csr_rdata, csr_invalid             CSR file response
//   wb_valid/wb_ready, wb_rd, wb_data,
//   illegal_insn                       writeback result
module csr_access_unit
  import rv32i_types_pkg::*;
  import csr_access_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  rs1_uimm,
  input  logic [4:0]  rd_addr,
  input  logic        flush,
  output logic        csr_swap,
  output logic        csr_clr,
  output logic        csr_set,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_invalid,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal_insn
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  csr_acc_state_t   state, next_state;
  logic             started;
  logic [CNT_W-1:0] settle_cnt;

  logic [2:0]       f3_q;
  csr_addr_t        addr_q;
  word_t            data_q;
  logic [4:0]       uimm_q;
  reg_idx_t         rd_q;
  word_t            wb_data_q;
  logic             illegal_q;

  logic             dec_swap, dec_set, dec_clr, dec_illegal;
  word_t            dec_operand;
  logic             ro_block;
  logic             issue_wr;
  logic             accept;

  // Decode runs on the latched fields so strobes depend only on registers.
  csr_op_decode u_decode (
    .funct3   (f3_q),
    .rs1_data (data_q),
    .rs1_uimm (uimm_q),
    .swap     (dec_swap),
    .set      (dec_set),
    .clr      (dec_clr),
    .illegal  (dec_illegal),
    .operand  (dec_operand)
  );

`ifdef CSR_RO_WRITE_CHECK_EN
  assign ro_block = (addr_q[11:10] == CSR_RO_BITS) && (dec_swap || dec_set || dec_clr);
`else
  assign ro_block = 1'b0;
`endif

  assign issue_wr = (dec_swap || dec_set || dec_clr) && !ro_block;

  // started keeps req_ready low until the first clock after reset release.
  assign accept = (state == IDLE) && started && (settle_cnt == '0) && req_valid && !flush;

  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    csr_swap     = 1'b0;
    csr_set      = 1'b0;
    csr_clr      = 1'b0;
    csr_addr_o   = 12'd0;
    csr_wdata    = 32'd0;
    wb_valid     = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'd0;
    illegal_insn = 1'b0;
    case (state)
      IDLE: begin
        req_ready = started && (settle_cnt == '0);
        if (accept) next_state = ISSUE;
      end
      ISSUE: begin
        // flush does not cancel the strobe: the write is already committed
        csr_swap   = dec_swap && !ro_block;
        csr_set    = dec_set && !ro_block;
        csr_clr    = dec_clr && !ro_block;
        csr_addr_o = addr_q;
        csr_wdata  = dec_operand;
        next_state = flush ? IDLE : RESP;
      end
      RESP: begin
        wb_valid     = 1'b1;
        wb_rd        = rd_q;
        wb_data      = wb_data_q;
        illegal_insn = illegal_q;
        if (flush || wb_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      started    <= 1'b0;
      settle_cnt <= '0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      data_q     <= '0;
      uimm_q     <= 5'd0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state   <= next_state;
      started <= 1'b1;
      if (accept) begin
        f3_q   <= funct3;
        addr_q <= csr_addr;
        data_q <= rs1_data;
        uimm_q <= rs1_uimm;
        rd_q   <= rd_addr;
      end
      if (state == ISSUE) begin
        wb_data_q <= csr_invalid ? 32'd0 : csr_rdata;
        illegal_q <= dec_illegal || ro_block || csr_invalid;
      end
      // The settle window only counts down while idle.
      if (state == ISSUE && issue_wr) settle_cnt <= SETTLE_LOAD;
      else if (state == IDLE && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - directed self-checking bench for csr_access_unit
module tb_csr_access_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req_valid, req_ready;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_uimm, rd_addr;
  logic        flush;
  logic        csr_swap, csr_clr, csr_set;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_invalid;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal_insn;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  csr_access_unit #(.SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .csr_addr(csr_addr), .rs1_data(rs1_data), .rs1_uimm(rs1_uimm),
    .rd_addr(rd_addr), .flush(flush), .csr_swap(csr_swap), .csr_clr(csr_clr),
    .csr_set(csr_set), .csr_addr_o(csr_addr_o), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_invalid(csr_invalid), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .illegal_insn(illegal_insn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nedge;
    @(negedge CLK);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 10 && req_ready !== 1'b1; i++) @(negedge CLK);
    chk(tag, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                           input logic [4:0] u, input logic [4:0] rd, input logic [31:0] rdat);
    req_valid = 1'b1;
    funct3    = f3;
    csr_addr  = a;
    rs1_data  = d;
    rs1_uimm  = u;
    rd_addr   = rd;
    csr_rdata = rdat;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0; req_valid = 1'b0; funct3 = 3'd0; csr_addr = 12'd0; rs1_data = 32'd0;
    rs1_uimm = 5'd0; rd_addr = 5'd0; flush = 1'b0; csr_rdata = 32'd0;
    csr_invalid = 1'b0; wb_ready = 1'b0;
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_strobes", {29'd0, csr_swap, csr_set, csr_clr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    nedge; nedge;
    nRST = 1'b1;
    nedge;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // CSRRW mscratch
    drive_req(3'b001, 12'h340, 32'hDEADBEEF, 5'd3, 5'd5, 32'h12345678);
    nedge; req_valid = 1'b0;
    chk("rw_swap", {31'd0, csr_swap}, 32'd1);
    chk("rw_setclr", {30'd0, csr_set, csr_clr}, 32'd0);
    chk("rw_addr", {20'd0, csr_addr_o}, 32'h340);
    chk("rw_wdata", csr_wdata, 32'hDEADBEEF);
    nedge;
    chk("rw_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("rw_wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("rw_wb_data", wb_data, 32'h12345678);
    chk("rw_illegal", {31'd0, illegal_insn}, 32'd0);
    chk("rw_resp_nostrobe", {31'd0, csr_swap}, 32'd0);
    chk("rw_resp_addr0", {20'd0, csr_addr_o}, 32'd0);
    wb_ready = 1'b1;
    nedge; wb_ready = 1'b0;
    chk("rw_wb_drop", {31'd0, wb_valid}, 32'd0);
    chk("rw_settle1", {31'd0, req_ready}, 32'd0);
    nedge;
    chk("rw_settle2", {31'd0, req_ready}, 32'd0);
    nedge;
    chk("rw_settle_done", {31'd0, req_ready}, 32'd1);

    // CSRRS mstatus with rs1=x0: pure read
    drive_req(3'b010, 12'h300, 32'hFFFF0000, 5'd0, 5'd7, 32'h00001888);
    nedge; req_valid = 1'b0;
    chk("rs0_strobes", {29'd0, csr_swap, csr_set, csr_clr}, 32'd0);
    chk("rs0_addr", {20'd0, csr_addr_o}, 32'h300);
    nedge;
    chk("rs0_wb_data", wb_data, 32'h00001888);
    chk("rs0_wb_rd", {27'd0, wb_rd}, 32'd7);
    chk("rs0_illegal", {31'd0, illegal_insn}, 32'd0);
    wb_ready = 1'b1;
    nedge; wb_ready = 1'b0;
    chk("rs0_no_settle", {31'd0, req_ready}, 32'd1);

    // CSRRCI mie, zimm 8
    drive_req(3'b111, 12'h304, 32'hFFFFFFFF, 5'b01000, 5'd3, 32'h000000AA);
    nedge; req_valid = 1'b0; wb_ready = 1'b1;
    chk("rci_clr", {29'd0, csr_swap, csr_set, csr_clr}, 32'd1);
    chk("rci_wdata", csr_wdata, 32'h00000008);
    nedge;
    chk("rci_wb_data", wb_data, 32'h000000AA);
    nedge; wb_ready = 1'b0;
    wait_ready("rci_ready");

    // CSRRW to a nonexistent CSR
    drive_req(3'b001, 12'h7FF, 32'h00000001, 5'd1, 5'd4, 32'hAAAA5555);
    csr_invalid = 1'b1;
    nedge; req_valid = 1'b0;
    chk("inv_swap", {31'd0, csr_swap}, 32'd1);
    nedge; csr_invalid = 1'b0;
    chk("inv_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("inv_illegal", {31'd0, illegal_insn}, 32'd1);
    chk("inv_wb_data", wb_data, 32'd0);
    wb_ready = 1'b1;
    nedge; wb_ready = 1'b0;
    wait_ready("inv_ready");

    // funct3 100 is not a CSR op
    drive_req(3'b100, 12'h340, 32'h0000FFFF, 5'd3, 5'd2, 32'h0);
    nedge; req_valid = 1'b0;
    chk("f100_strobes", {29'd0, csr_swap, csr_set, csr_clr}, 32'd0);
    nedge;
    chk("f100_illegal", {31'd0, illegal_insn}, 32'd1);
    wb_ready = 1'b1;
    nedge; wb_ready = 1'b0;
    chk("f100_no_settle", {31'd0, req_ready}, 32'd1);

    // back-to-back request held while RESP stalls, then flush in RESP
    drive_req(3'b001, 12'h340, 32'h11111111, 5'd1, 5'd9, 32'h22222222);
    nedge;
    chk("b2b_swap", {31'd0, csr_swap}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      nedge;
      chk("b2b_hold_valid", {31'd0, wb_valid}, 32'd1);
      chk("b2b_hold_nostrobe", {31'd0, csr_swap}, 32'd0);
      chk("b2b_hold_data", wb_data, 32'h22222222);
    end
    flush = 1'b1; wb_ready = 1'b1;
    nedge;
    flush = 1'b0; wb_ready = 1'b0; req_valid = 1'b0;
    chk("b2b_flush_drop", {31'd0, wb_valid}, 32'd0);
    chk("b2b_flush_nostrobe", {31'd0, csr_swap}, 32'd0);
    nedge;
    chk("b2b_no_second", {31'd0, csr_swap}, 32'd0);
    wait_ready("b2b_ready");

    // flush in IDLE blocks acceptance
    drive_req(3'b001, 12'h340, 32'h33333333, 5'd1, 5'd1, 32'h0);
    flush = 1'b1;
    nedge; req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_nostrobe", {31'd0, csr_swap}, 32'd0);
    nedge;
    chk("idle_flush_nowb", {31'd0, wb_valid}, 32'd0);

    // flush in ISSUE: strobe still driven, result dropped
    drive_req(3'b001, 12'h340, 32'h44444444, 5'd1, 5'd10, 32'h55555555);
    nedge; req_valid = 1'b0; flush = 1'b1;
    #1;
    chk("iss_flush_swap", {31'd0, csr_swap}, 32'd1);
    nedge; flush = 1'b0;
    chk("iss_flush_nowb", {31'd0, wb_valid}, 32'd0);
    chk("iss_flush_settle", {31'd0, req_ready}, 32'd0);
    wait_ready("iss_flush_ready");

    // reset during ISSUE
    drive_req(3'b001, 12'h340, 32'h66666666, 5'd1, 5'd11, 32'h0);
    nedge; req_valid = 1'b0;
    chk("rst_iss_swap", {31'd0, csr_swap}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rst_iss_swap_drop", {31'd0, csr_swap}, 32'd0);
    chk("rst_iss_addr_drop", {20'd0, csr_addr_o}, 32'd0);
    chk("rst_iss_wdata_drop", csr_wdata, 32'd0);
    nedge; nRST = 1'b1;
    nedge;
    chk("rst_iss_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_iss_nowb", {31'd0, wb_valid}, 32'd0);

`ifdef CSR_RO_WRITE_CHECK_EN
    // write to read-only cycle CSR
    drive_req(3'b001, 12'hC00, 32'h00000005, 5'd1, 5'd1, 32'h00000100);
    nedge; req_valid = 1'b0;
    chk("ro_w_nostrobe", {29'd0, csr_swap, csr_set, csr_clr}, 32'd0);
    nedge;
    chk("ro_w_illegal", {31'd0, illegal_insn}, 32'd1);
    wb_ready = 1'b1;
    nedge; wb_ready = 1'b0;
    chk("ro_w_no_settle", {31'd0, req_ready}, 32'd1);

    // pure read of the same CSR stays legal
    drive_req(3'b010, 12'hC00, 32'h00000005, 5'd0, 5'd2, 32'h00001234);
    nedge; req_valid = 1'b0;
    chk("ro_r_nostrobe", {29'd0, csr_swap, csr_set, csr_clr}, 32'd0);
    nedge;
    chk("ro_r_illegal", {31'd0, illegal_insn}, 32'd0);
    chk("ro_r_data", wb_data, 32'h00001234);
    wb_ready = 1'b1;
    nedge; wb_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
